ptc_vp12_pwr_seq: RTL and testbench
===================================

Name: ptc_vp12_pwr_seq

Overview:
- Downstream consumer of the PTC control register bank. Turns per-WIB 12 V enable request bits into staggered VP12_EN outputs.
- Trips individual channels on a debounced IV alert. Trips all channels on any over-temperature input.
- Returns channel-on and latched-fault status for the read-only register words.
- Prevents simultaneous inrush across WIB slots.

Parameters:
- N_CH, 6, number of 12 V channels (VP12_EN0..5).
- STAGGER_CYCLES, 1000000, minimum clk_axi cycles between successive turn-ons. Must be >=1; 10 ms at 100 MHz.
- FILT_LEN, 16, consecutive high samples of a synchronized alert needed to trip. Must be >=1.
- N_OT, 3, number of over-temperature inputs.

Ports:
- clk_axi  in  1  AXI-domain clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- ch_en_req  in  N_CH  level requests from the rw register, synchronous to clk_axi.
- clr_fault  in  1  one-cycle pulse that clears latched faults.
- iv_alert  in  N_CH  asynchronous, active-high per-channel alerts.
- over_temp  in  N_OT  asynchronous, active-high over-temperature inputs.
- vp12_en  out  N_CH  registered channel enables to pins.
- fault_ch  out  N_CH  latched per-channel alert trips.
- ot_fault  out  1  latched over-temperature trip.
- busy  out  1  high when state != IDLE or any channel is eligible.
- seq_state  out  2  current FSM state code.

Behaviour:
- Reset (async assert, sync release):
  - vp12_en, fault_ch, ot_fault, busy = 0.
  - seq_state = IDLE; all counters and synchronizers = 0.
  - Asserting rst mid-sequence drops all enables immediately, with no clock required.
- Input synchronization: iv_alert and over_temp each pass through a 2-FF synchronizer. The trip action is registered on the following edge, so outputs respond on the 3rd rising edge that samples the input high.
- Eligibility: eligible[i] = ch_en_req[i] & ~fault_ch[i] & ~vp12_en[i] & ~ot_fault.
- FSM states: IDLE=0, GAP=1, TRIP=2 (code 3 unused; decodes to IDLE).
- IDLE:
  - If any channel is eligible, set vp12_en[lowest eligible index]=1 on the next edge.
  - Load gap_cnt = STAGGER_CYCLES-1 and go to GAP.
- GAP:
  - Decrement gap_cnt each cycle; when gap_cnt==0, go to IDLE.
  - Turn-on edges are therefore exactly STAGGER_CYCLES+1 cycles apart.
  - gap_cnt width is clog2(STAGGER_CYCLES)+1 bits; no wrap.
- Turn-off:
  - vp12_en[i] clears on the edge after ch_en_req[i] is sampled low, in any state.
  - The off request wins over a same-cycle turn-on of channel i.
  - Turn-offs do not restart or extend the gap.
- Alert filter, per channel:
  - filt_cnt[i] increments while alert_sync[i] & vp12_en[i], saturating at FILT_LEN.
  - filt_cnt[i] clears when alert_sync[i] is low or the channel is off.
  - When filt_cnt[i] reaches FILT_LEN: vp12_en[i]<=0 and fault_ch[i]<=1 on the same edge.
  - Other channels and the FSM are unaffected.
- Over-temperature (OR of all ot_sync):
  - In any state, on the next edge: vp12_en<=0, ot_fault<=1, state<=TRIP, gap_cnt cleared.
  - Over-temperature takes priority over every other event.
  - An alert trip in the same cycle still latches its fault_ch bit.
- TRIP:
  - Stay in TRIP while ot_fault is set.
  - clr_fault with all ot_sync low: ot_fault<=0, fault_ch<=0, go to IDLE.
  - clr_fault while any ot_sync is high is ignored.
- clr_fault in IDLE/GAP:
  - Clears fault_ch on the next edge.
  - Channels whose request is still high become eligible and re-enter the stagger order.
- Simultaneous requests: channels are turned on one per gap, in ascending index order. A later request for a lower index jumps ahead of higher indices still waiting.

Decomposition:
- Package ptc_pwr_pkg holds:
  - state encoding constants IDLE/GAP/TRIP and the seq_state width (2);
  - default STAGGER_CYCLES, FILT_LEN and N_CH;
  - a lowest-set-bit priority function.
- Sub-module ptc_alert_filter: 2-FF synchronizer plus saturating consecutive-sample counter, with gate input (vp12_en[i]) and trip output. Instantiated N_CH times.
- The over_temp synchronizers are plain 2-FF instances inside the top.

Test Plan (sim params STAGGER_CYCLES=8, FILT_LEN=4):
- Reset, then ch_en_req=6'b111111 in one cycle → vp12_en bits 0..5 rise in order, each 9 cycles apart; busy falls after the last gap.
- All channels on, ch_en_req[3] dropped → vp12_en[3]=0 exactly 1 cycle later, others unchanged, seq_state stays IDLE.
- iv_alert[2] high for 5 cycles with channel on → vp12_en[2]=0 and fault_ch[2]=1. A 3-cycle pulse instead → no trip. After clr_fault, channel 2 re-enables.
- over_temp[1] pulsed high mid-GAP → on the 3rd edge vp12_en=0, ot_fault=1, seq_state=2. clr_fault while over_temp is still high → stays in TRIP. After it goes low, clr_fault → IDLE and the sequence restarts.
- rst asserted mid-GAP with 3 channels on → all outputs 0 asynchronously. After release, requests re-sequence from channel 0.
- ch_en_req[4] raised during channel 5's gap → channel 4 turns on next, ahead of no one; ordering and the 9-cycle spacing are preserved.

Source files
------------

// File: rtl/ptc_pwr_pkg.sv
// rtl/ptc_pwr_pkg.sv - shared constants, state encoding and priority helper for the VP12 power sequencer
package ptc_pwr_pkg;

    localparam int SEQ_W              = 2;
    localparam int MAX_CH             = 32;
    localparam int DEF_N_CH           = 6;
    localparam int DEF_STAGGER_CYCLES = 1000000;
    localparam int DEF_FILT_LEN       = 16;
    localparam int DEF_N_OT           = 3;

    typedef enum logic [SEQ_W-1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        TRIP = 2'd2
    } seq_state_e;

    // Isolates the lowest set bit; the result is one-hot or zero.
    function automatic logic [MAX_CH-1:0] lowest_set(input logic [MAX_CH-1:0] v);
        return v & (~v + MAX_CH'(1));
    endfunction

endpackage

// File: rtl/ptc_alert_filter.sv
// rtl/ptc_alert_filter.sv - alert synchronizer with gated consecutive-sample trip counter
module ptc_alert_filter
    import ptc_pwr_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic alert,
    input  logic gate,
    output logic trip
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN);

    logic          alert_meta;
    logic          alert_sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alert_meta <= 1'b0;
            alert_sync <= 1'b0;
        end else begin
            alert_meta <= alert;
            alert_sync <= alert_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!(alert_sync && gate)) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires on the edge where the counter would reach FILT_LEN.
    assign trip = alert_sync & gate & (cnt == CNT_MAX - CW'(1));

endmodule

// File: rtl/ptc_vp12_pwr_seq.sv
// rtl/ptc_vp12_pwr_seq.sv - staggered 12 V channel enable sequencer with alert and over-temperature trips
module ptc_vp12_pwr_seq
    import ptc_pwr_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int FILT_LEN       = DEF_FILT_LEN,
    parameter int N_OT           = DEF_N_OT
) (
    input  logic             clk_axi,
    input  logic             rst,
    input  logic [N_CH-1:0]  ch_en_req,
    input  logic             clr_fault,
    input  logic [N_CH-1:0]  iv_alert,
    input  logic [N_OT-1:0]  over_temp,
    output logic [N_CH-1:0]  vp12_en,
    output logic [N_CH-1:0]  fault_ch,
    output logic             ot_fault,
    output logic             busy,
    output logic [SEQ_W-1:0] seq_state
);

    localparam int GAP_W = $clog2(STAGGER_CYCLES) + 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STAGGER_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [N_CH-1:0]   en_d, flt_d;
    logic              ot_d;
    logic [N_OT-1:0]   ot_meta, ot_sync;
    logic              ot_any;
    logic [N_CH-1:0]   trip_vec;
    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   turn_on;
    logic [MAX_CH-1:0] elig_w, pick;
    logic              unused_pick_hi;

    always_ff @(posedge clk_axi or posedge rst) begin
        if (rst) begin
            ot_meta <= '0;
            ot_sync <= '0;
        end else begin
            ot_meta <= over_temp;
            ot_sync <= ot_meta;
        end
    end

    assign ot_any = |ot_sync;

    for (genvar i = 0; i < N_CH; i++) begin : g_filt
        ptc_alert_filter #(
            .FILT_LEN (FILT_LEN)
        ) u_filt (
            .clk   (clk_axi),
            .rst   (rst),
            .alert (iv_alert[i]),
            .gate  (vp12_en[i]),
            .trip  (trip_vec[i])
        );
    end

    assign eligible       = ch_en_req & ~fault_ch & ~vp12_en & {N_CH{~ot_fault}};
    assign elig_w         = MAX_CH'(eligible);
    assign pick           = lowest_set(elig_w);
    assign turn_on        = pick[N_CH-1:0];
    assign unused_pick_hi = |(pick >> N_CH);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        en_d    = vp12_en & ch_en_req & ~trip_vec;
        flt_d   = fault_ch | trip_vec;
        ot_d    = ot_fault;

        case (state_q)
            GAP: begin
                if (clr_fault) flt_d = trip_vec;
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            TRIP: begin
                if (clr_fault && !ot_any) begin
                    ot_d    = 1'b0;
                    flt_d   = trip_vec;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                if (clr_fault) flt_d = trip_vec;
                if (|eligible) begin
                    // turn_on is a subset of ch_en_req, so a same-cycle off request still wins
                    en_d    = en_d | turn_on;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
        endcase

        if (ot_any) begin
            en_d    = '0;
            ot_d    = 1'b1;
            flt_d   = fault_ch | trip_vec;
            gap_d   = '0;
            state_d = TRIP;
        end
    end

    always_ff @(posedge clk_axi or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            vp12_en  <= '0;
            fault_ch <= '0;
            ot_fault <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            vp12_en  <= en_d;
            fault_ch <= flt_d;
            ot_fault <= ot_d;
        end
    end

    assign seq_state = state_q;
    assign busy      = ~rst & ((state_q != IDLE) | (|eligible));

endmodule

// File: tb/tb_ptc_vp12_pwr_seq.sv
// tb/tb_ptc_vp12_pwr_seq.sv - scoreboard bench for the VP12 power sequencer
module tb_ptc_vp12_pwr_seq;

    localparam int N_CH = 6;
    localparam int N_OT = 3;

    typedef struct {
        logic [5:0] en;
        logic [5:0] flt;
        logic       ot;
        logic [1:0] st;
        int         gap;
    } exp_t;

    logic            clk_axi = 1'b0;
    logic            rst     = 1'b1;
    logic [N_CH-1:0] ch_en_req = '0;
    logic            clr_fault = 1'b0;
    logic [N_CH-1:0] iv_alert  = '0;
    logic [N_OT-1:0] over_temp = '0;
    logic [N_CH-1:0] vp12_en;
    logic [N_CH-1:0] fault_ch;
    logic            ot_fault;
    logic            busy;
    logic [1:0]      seq_state;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_ev = 0;
    logic [12:0] prev = '0;

    ptc_vp12_pwr_seq #(
        .N_CH           (N_CH),
        .STAGGER_CYCLES (8),
        .FILT_LEN       (4),
        .N_OT           (N_OT)
    ) dut (
        .clk_axi   (clk_axi),
        .rst       (rst),
        .ch_en_req (ch_en_req),
        .clr_fault (clr_fault),
        .iv_alert  (iv_alert),
        .over_temp (over_temp),
        .vp12_en   (vp12_en),
        .fault_ch  (fault_ch),
        .ot_fault  (ot_fault),
        .busy      (busy),
        .seq_state (seq_state)
    );

    always #5 clk_axi = ~clk_axi;

    task automatic push(input logic [5:0] en, input logic [5:0] flt, input logic ot,
                        input logic [1:0] st, input int gap);
        exp_t e;
        e.en = en; e.flt = flt; e.ot = ot; e.st = st; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_axi);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_en(input logic [5:0] val);
        int t = 0;
        while (vp12_en !== val && t < 200) begin
            tick(1);
            t++;
        end
        chk("wait_en_reached", {26'd0, vp12_en}, {26'd0, val});
    endtask

    // Monitor: any change of the enable/fault outputs is an output event matched against the queue.
    always @(negedge clk_axi) begin
        logic [12:0] cur;
        exp_t e;
        cyc++;
        cur = {vp12_en, fault_ch, ot_fault};
        if (cur !== prev) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: en=%0h flt=%0h ot=%0b st=%0d at cycle %0d",
                         vp12_en, fault_ch, ot_fault, seq_state, cyc);
            end else begin
                e = q.pop_front();
                if (e.en !== vp12_en || e.flt !== fault_ch || e.ot !== ot_fault ||
                    e.st !== seq_state || (e.gap >= 0 && (cyc - last_ev) != e.gap)) begin
                    n_bad++;
                    $display("FAIL event: got en=%0h flt=%0h ot=%0b st=%0d gap=%0d expected en=%0h flt=%0h ot=%0b st=%0d gap=%0d",
                             vp12_en, fault_ch, ot_fault, seq_state, cyc - last_ev,
                             e.en, e.flt, e.ot, e.st, e.gap);
                end
            end
            prev    = cur;
            last_ev = cyc;
        end
    end

    initial begin
        // reset state
        tick(3);
        chk("rst_en", {26'd0, vp12_en}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        tick(1);
        chk("rst_flt", {26'd0, fault_ch}, 32'h0);
        chk("rst_ot", {31'd0, ot_fault}, 32'h0);
        chk("rst_state", {30'd0, seq_state}, 32'h0);

        // all six requested at once: ascending, 9 cycles apart
        push(6'h01, 6'h00, 1'b0, 2'd1, -1);
        push(6'h03, 6'h00, 1'b0, 2'd1, 9);
        push(6'h07, 6'h00, 1'b0, 2'd1, 9);
        push(6'h0F, 6'h00, 1'b0, 2'd1, 9);
        push(6'h1F, 6'h00, 1'b0, 2'd1, 9);
        push(6'h3F, 6'h00, 1'b0, 2'd1, 9);
        ch_en_req = 6'h3F;
        #1;
        chk("busy_on_request", {31'd0, busy}, 32'h1);
        wait_en(6'h3F);
        tick(12);
        chk("busy_after_last_gap", {31'd0, busy}, 32'h0);
        chk("idle_after_last_gap", {30'd0, seq_state}, 32'h0);

        // drop channel 3, then a 5-cycle alert on channel 2
        push(6'h37, 6'h00, 1'b0, 2'd0, -1);
        push(6'h33, 6'h04, 1'b0, 2'd0, 6);
        ch_en_req = 6'h37;
        tick(1);
        iv_alert = 6'h04;
        tick(5);
        iv_alert = 6'h00;
        tick(2);
        chk("state_idle_after_off", {30'd0, seq_state}, 32'h0);

        // 3-cycle alert on channel 0 must not trip
        tick(4);
        iv_alert = 6'h01;
        tick(3);
        iv_alert = 6'h00;
        tick(8);
        chk("short_pulse_no_trip", {26'd0, fault_ch}, 32'h04);

        // clear fault: channel 2 re-enters one cycle after the clear
        push(6'h33, 6'h00, 1'b0, 2'd0, -1);
        push(6'h37, 6'h00, 1'b0, 2'd1, 1);
        clr_fault = 1'b1;
        tick(1);
        clr_fault = 1'b0;
        tick(12);

        // over-temperature mid-gap
        push(6'h3F, 6'h00, 1'b0, 2'd1, -1);
        push(6'h00, 6'h00, 1'b1, 2'd2, 5);
        ch_en_req = 6'h3F;
        tick(3);
        over_temp = 3'b010;
        tick(5);
        clr_fault = 1'b1;
        tick(1);
        clr_fault = 1'b0;
        tick(2);
        chk("trip_held_state", {30'd0, seq_state}, 32'h2);
        chk("trip_held_ot", {31'd0, ot_fault}, 32'h1);
        over_temp = 3'b000;
        tick(4);
        push(6'h00, 6'h00, 1'b0, 2'd0, -1);
        push(6'h01, 6'h00, 1'b0, 2'd1, 1);
        push(6'h03, 6'h00, 1'b0, 2'd1, 9);
        push(6'h07, 6'h00, 1'b0, 2'd1, 9);
        clr_fault = 1'b1;
        tick(1);
        clr_fault = 1'b0;
        wait_en(6'h07);

        // asynchronous reset mid-gap
        tick(3);
        push(6'h00, 6'h00, 1'b0, 2'd0, -1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", {26'd0, vp12_en}, 32'h0);
        chk("async_rst_busy", {31'd0, busy}, 32'h0);
        chk("async_rst_state", {30'd0, seq_state}, 32'h0);
        ch_en_req = 6'h2F;
        tick(2);
        push(6'h01, 6'h00, 1'b0, 2'd1, -1);
        push(6'h03, 6'h00, 1'b0, 2'd1, 9);
        push(6'h07, 6'h00, 1'b0, 2'd1, 9);
        push(6'h0F, 6'h00, 1'b0, 2'd1, 9);
        push(6'h2F, 6'h00, 1'b0, 2'd1, 9);
        push(6'h3F, 6'h00, 1'b0, 2'd1, 9);
        rst = 1'b0;

        // channel 4 requested during channel 5's gap
        wait_en(6'h2F);
        tick(3);
        ch_en_req = 6'h3F;
        wait_en(6'h3F);
        tick(12);
        chk("final_busy", {31'd0, busy}, 32'h0);

        begin
            int t = 0;
            while (q.size() != 0 && t < 100) begin
                tick(1);
                t++;
            end
        end
        chk("queue_drained", q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
